// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the sequenced serial-parallel multiplier.
// Consumed by spm_seq_if, spm_csa_cell and spm_seq via import spm_pkg::*.
package spm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int DEFAULT_WIDTH = 32;

   // Bits needed to count the 2*width serial steps of one multiplication.
   function automatic int cnt_width(input int width);
      return $clog2(2 * width);
   endfunction

endpackage

// File: rtl/spm_seq_if.sv
// Operand/product handshake bundle for spm_seq.
// The slave modport is the multiplier's view; master is the producer/consumer side.
import spm_pkg::*;

interface spm_seq_if #(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   y;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] p;
   logic               busy;

   modport master (
      output in_valid, x, y, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, x, y, out_ready,
      output in_ready, out_valid, p, busy
   );

endinterface

// File: rtl/spm_csa_cell.sv
// One carry-save bit of the serial-parallel multiplier chain.
// Sum and carry are registered; clr restarts the cell for a new product.
import spm_pkg::*;

module spm_csa_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic a,
   input  logic sin,
   output logic sum,
   output logic sum_q
);

   logic c_q;

   // Full-adder sum of the partial-product bit, the upstream sum and our carry.
   always_comb begin
      sum = a ^ sin ^ c_q;
   end

   // Hold sum/carry between steps; reset or a new operand wipes the cell.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         sum_q <= 1'b0;
         c_q   <= 1'b0;
      end else if (en) begin
         sum_q <= sum;
         c_q   <= (a & sin) | (a & c_q) | (sin & c_q);
      end
   end

endmodule

// File: rtl/spm_seq.sv
// Sequenced serial-parallel multiplier: accepts x/y in parallel, streams y
// LSB-first through a CSA chain for 2*WIDTH steps, then presents the product.
// Build option SPM_SEQ_UNSIGNED_EN: treat operands as unsigned (y zero-extends,
// top cell becomes an ordinary CSA cell). Default is two's complement.
import spm_pkg::*;

module spm_seq #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic     clk,
   input logic     rst,
   spm_seq_if.slave bus
);

   localparam int            PW   = 2 * WIDTH;
   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(PW - 1);

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] x_r;
   logic [WIDTH-1:0] y_sh;
   logic [PW-1:0]    p_sh;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic             ybit;
   logic             pbit;
   logic             run;
   logic             start;
   logic [WIDTH-1:0] sum_c;
   logic [WIDTH-1:0] sum_q;
   logic             unused_sums;

   assign ybit  = y_sh[0];
   assign run   = (state == RUN);
   assign start = (state == IDLE) && in_ready_q && bus.in_valid;
   assign pbit  = sum_c[0];

   // Ordinary CSA cells; each takes its upstream sum from the cell above.
   for (genvar i = 0; i < WIDTH - 1; i++) begin : g_csa
      spm_csa_cell u_cell (
         .clk   (clk),
         .rst   (rst),
         .clr   (start),
         .en    (run),
         .a     (x_r[i] & ybit),
         .sin   (sum_q[i+1]),
         .sum   (sum_c[i]),
         .sum_q (sum_q[i])
      );
   end

`ifdef SPM_SEQ_UNSIGNED_EN
   // Unsigned build: the top bit has positive weight, so it is a plain CSA cell.
   spm_csa_cell u_top_cell (
      .clk   (clk),
      .rst   (rst),
      .clr   (start),
      .en    (run),
      .a     (x_r[WIDTH-1] & ybit),
      .sin   (1'b0),
      .sum   (sum_c[WIDTH-1]),
      .sum_q (sum_q[WIDTH-1])
   );
`else
   logic tc_a;
   logic tc_sum;
   logic tc_sum_q;
   logic tc_z;

   assign tc_a   = x_r[WIDTH-1] & ybit;
   assign tc_sum = tc_a ^ tc_z;
   assign sum_c[WIDTH-1] = tc_sum;
   assign sum_q[WIDTH-1] = tc_sum_q;

   // Sign cell: serially negates the x-MSB partial-product stream (copy up to the first 1, invert after).
   always_ff @(posedge clk) begin
      if (!rst || start) begin
         tc_sum_q <= 1'b0;
         tc_z     <= 1'b0;
      end else if (run) begin
         tc_sum_q <= tc_sum;
         tc_z     <= tc_z | tc_a;
      end
   end
`endif

   assign unused_sums = ^sum_c[WIDTH-1:1];

   // Control FSM plus operand/product shifters; handshake outputs are registered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         count       <= '0;
         x_r         <= '0;
         y_sh        <= '0;
         p_sh        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (start) begin
                  x_r        <= bus.x;
                  y_sh       <= bus.y;
                  count      <= '0;
                  state      <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
`ifdef SPM_SEQ_UNSIGNED_EN
               y_sh <= {1'b0, y_sh[WIDTH-1:1]};
`else
               y_sh <= {y_sh[WIDTH-1], y_sh[WIDTH-1:1]};
`endif
               p_sh  <= {pbit, p_sh[PW-1:1]};
               count <= count + CW'(1);
               if (count == LAST) begin
                  count       <= '0;
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.p         = p_sh;

endmodule

// File: tb/tb_spm_seq.sv
// Self-checking bench for spm_seq (WIDTH=32) using a product scoreboard.
// Honours SPM_SEQ_UNSIGNED_EN in its reference model.
module tb_spm_seq;

   localparam int W     = 32;
   localparam int LAT   = 2 * W;
   localparam int LIMIT = LAT + 20;

   logic clk = 1'b0;
   logic rst;

   spm_seq_if #(.WIDTH(W)) bus ();

   spm_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [63:0] held;
   int          wait_n;

   // Reference product, independent of the serial datapath.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef SPM_SEQ_UNSIGNED_EN
      return {32'b0, a} * {32'b0, b};
`else
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
`endif
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer an operand pair, wait for the block to take it, and log the expected product.
   task automatic apply_stimulus(input logic [31:0] xa, input logic [31:0] ya, output int n);
      n = 0;
      bus.in_valid = 1'b1;
      bus.x = xa;
      bus.y = ya;
      while (!bus.in_ready && n < LIMIT) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("accept_in_time", 64'(n < LIMIT), 64'd1);
      exp_q.push_back(model(xa, ya));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_output("busy_after_accept", 64'(bus.busy), 64'd1);
   endtask

   // Wait for out_valid, check latency and product, optionally check the one-cycle pulse.
   task automatic wait_result(input bit expect_pulse);
      int n;
      logic [63:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.out_valid && n < LIMIT);
      check_output("latency", 64'(n), 64'(LAT));
      check_output("product", bus.p, e);
      held = e;
      if (expect_pulse) begin
         @(posedge clk);
         #1;
         check_output("valid_pulse", 64'(bus.out_valid), 64'd0);
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x = '0;
      bus.y = '0;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_output("rst_busy", 64'(bus.busy), 64'd0);
      check_output("rst_p", bus.p, 64'd0);

      bus.in_valid = 1'b1;
      bus.x = 32'd3;
      bus.y = 32'd5;
      @(posedge clk);
      #1;
      check_output("rst_wins_busy", 64'(bus.busy), 64'd0);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_output("release_in_ready", 64'(bus.in_ready), 64'd1);
      check_output("release_busy", 64'(bus.busy), 64'd0);

      $display("[TB] directed products");
      bus.out_ready = 1'b1;
      apply_stimulus(32'd3, 32'd5, wait_n);
      wait_result(1'b1);
      apply_stimulus(32'hFFFF_FFF9, 32'd6, wait_n);
      check_output("throughput_gap", 64'(wait_n), 64'd0);
      wait_result(1'b1);
      apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, wait_n);
      wait_result(1'b1);
      apply_stimulus(32'h8000_0000, 32'h8000_0000, wait_n);
      wait_result(1'b1);
      apply_stimulus(32'h7FFF_FFFF, 32'h8000_0000, wait_n);
      wait_result(1'b1);
      apply_stimulus(32'h0000_0000, 32'h1234_5678, wait_n);
      wait_result(1'b1);

      $display("[TB] random products");
      for (int i = 0; i < 4; i++) begin
         apply_stimulus($urandom, $urandom, wait_n);
         wait_result(1'b1);
      end

      $display("[TB] backpressure");
      bus.out_ready = 1'b0;
      apply_stimulus(32'd5, 32'hFFFF_FFF9, wait_n);
      wait_result(1'b0);
      bus.in_valid = 1'b1;
      bus.x = 32'd11;
      bus.y = 32'd13;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check_output("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check_output("bp_p_stable", bus.p, held);
         check_output("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_output("bp_release_valid", 64'(bus.out_valid), 64'd0);
      check_output("bp_release_ready", 64'(bus.in_ready), 64'd1);
      apply_stimulus(32'd11, 32'd13, wait_n);
      check_output("bp_second_accept", 64'(wait_n), 64'd0);
      wait_result(1'b1);

      $display("[TB] reset during run");
      apply_stimulus(32'd9, 32'd9, wait_n);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      void'(exp_q.pop_back());
      check_output("midrst_busy", 64'(bus.busy), 64'd0);
      check_output("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_output("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      check_output("midrst_out_valid2", 64'(bus.out_valid), 64'd0);
      check_output("midrst_busy2", 64'(bus.busy), 64'd0);
      apply_stimulus(32'd2, 32'hFFFF_FFFD, wait_n);
      wait_result(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
